// File: rtl/spu_pkg.sv
// Package shared by the SPU event transmitter and the PMU receiver.
// Holds the default event-ID width, the event-ID type and the "no event" value.
package spu_pkg;
  localparam int EID_WIDTH = 8;

  typedef logic [EID_WIDTH-1:0] e_id_t;

  // e_id == 0 on the link means "no event this cycle"
  localparam e_id_t EID_NONE = '0;
endpackage

// File: rtl/spu_event_tx_if.sv
// Source-side handshake bundle for spu_event_tx.
//   src_valid : per-source request, held until granted
//   src_eid   : per-source event ID, stable while valid
//   src_ready : one-hot grant from the transmitter (combinational)
// master = event sources, slave = transmitter.
interface spu_event_tx_if #(
  parameter int NUM_SRC   = 4,
  parameter int EID_WIDTH = spu_pkg::EID_WIDTH
);
  logic [NUM_SRC-1:0]                src_valid;
  logic [NUM_SRC-1:0][EID_WIDTH-1:0] src_eid;
  logic [NUM_SRC-1:0]                src_ready;

  modport master (output src_valid, output src_eid, input  src_ready);
  modport slave  (input  src_valid, input  src_eid, output src_ready);
endinterface

// File: rtl/spu_evt_fifo.sv
// Small synchronous event FIFO.
//   push/din   : write din when push and not full
//   pop/head   : head is the oldest entry; pop removes it when not empty
//   flush      : synchronous clear, wins over push/pop
//   full/empty : status from registered pointers
//   count      : number of stored entries (0..DEPTH)
// Pointers carry one extra MSB so full and empty differ when the
// index bits are equal.
module spu_evt_fifo import spu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = EID_WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count,
  output logic [W-1:0] head
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spu_event_tx.sv
// Transmit end of the SPU event interface feeding the PMU event counters.
// Round-robin arbitrates up to NUM_SRC event sources, buffers events in a
// small FIFO and drives one registered event ID per cycle on e_id_o
// (0 = no event).
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   enable_i       : 0 blocks new grants, buffered events still drain
//   flush_i        : synchronous clear of buffered events and output
//   src_if (slave) : per-source valid / eid / one-hot ready
//   e_id_o         : registered event ID
//   sent_cnt_o     : nonzero IDs loaded into e_id_o (wraps)
//   drop_cnt_o     : zero-ID handshakes discarded (saturates)
module spu_event_tx #(
  parameter int NUM_SRC    = 4,
  parameter int EID_WIDTH  = spu_pkg::EID_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 flush_i,
  spu_event_tx_if.slave        src_if,
  output logic [EID_WIDTH-1:0] e_id_o,
  output logic [CNT_WIDTH-1:0] sent_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
);
  localparam int PTR_W = $clog2(NUM_SRC);
  localparam int AW    = $clog2(FIFO_DEPTH);

  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [EID_WIDTH-1:0] e_id_q, e_id_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [AW:0]          fifo_cnt;
  logic [EID_WIDTH-1:0] fifo_head;

  logic                 grant_ok, hs, hs_nz, hs_zero;
  logic [PTR_W-1:0]     gnt, cand;
  logic [EID_WIDTH-1:0] gid;
  logic [NUM_SRC-1:0]   ready;
  int                   idx;

  // Ready is combinational, so it is gated by reset explicitly.
  assign grant_ok = !rst_i && enable_i && !flush_i &&
                    (fifo_cnt < (AW+1)'(FIFO_DEPTH));

  // First valid source at or after rr_q, wrapping.
  always_comb begin
    hs   = 1'b0;
    gnt  = '0;
    idx  = 0;
    cand = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      cand = PTR_W'(idx);
      if (!hs && grant_ok && src_if.src_valid[cand]) begin
        hs  = 1'b1;
        gnt = cand;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (hs) ready[gnt] = 1'b1;
  end
  assign src_if.src_ready = ready;

  assign gid     = src_if.src_eid[gnt];
  assign hs_nz   = hs && (gid != '0);
  assign hs_zero = hs && (gid == '0);

  // A new event only queues behind older ones; with an empty FIFO it
  // bypasses straight into the output register.
  assign fifo_pop  = !flush_i && !fifo_empty;
  assign fifo_push = hs_nz && !fifo_empty && !fifo_full;

  spu_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EID_WIDTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .din   (gid),
    .pop   (fifo_pop),
    .flush (flush_i),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt),
    .head  (fifo_head)
  );

  always_comb begin
    if (flush_i)          e_id_d = '0;
    else if (!fifo_empty) e_id_d = fifo_head;
    else if (hs_nz)       e_id_d = gid;
    else                  e_id_d = '0;

    sent_d = sent_q + CNT_WIDTH'(|e_id_d);

    drop_d = drop_q;
    if (hs_zero && !(&drop_q)) drop_d = drop_q + CNT_WIDTH'(1);

    rr_d = rr_q;
    if (hs) rr_d = (gnt == PTR_W'(NUM_SRC-1)) ? '0 : gnt + PTR_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_id_q <= '0;
      sent_q <= '0;
      drop_q <= '0;
      rr_q   <= '0;
    end else begin
      e_id_q <= e_id_d;
      sent_q <= sent_d;
      drop_q <= drop_d;
      rr_q   <= rr_d;
    end
  end

  assign e_id_o     = e_id_q;
  assign sent_cnt_o = sent_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_spu_event_tx.sv
// Randomised bench for spu_event_tx with a queue-based reference model.
// Narrow counters make wrap and saturation reachable in a short run.
module tb_spu_event_tx;
  import spu_pkg::*;

  localparam int NS    = 4;
  localparam int EW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [EW-1:0] e_id_o;
  logic [CW-1:0] sent_cnt_o, drop_cnt_o;

  spu_event_tx_if #(.NUM_SRC(NS), .EID_WIDTH(EW)) sif ();

  spu_event_tx #(
    .NUM_SRC(NS), .EID_WIDTH(EW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable_i), .flush_i(flush_i),
    .src_if(sif), .e_id_o(e_id_o), .sent_cnt_o(sent_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // source state
  bit [NS-1:0] pend;
  e_id_t       ids [NS];
  bit          en, fl, rand_src;

  // reference model
  e_id_t         mq [$];
  e_id_t         m_eid;
  logic [CW-1:0] m_sent, m_drop;
  int            m_rr;

  task automatic model_reset();
    mq.delete();
    m_eid  = '0;
    m_sent = '0;
    m_drop = '0;
    m_rr   = 0;
    pend   = '0;
  endtask

  task automatic step();
    bit            hs;
    int            g;
    e_id_t         gid;
    logic [NS-1:0] exp_rdy;
    @(negedge clk);
    if (rand_src)
      for (int s = 0; s < NS; s++)
        if (!pend[s] && $urandom_range(0, 2) != 0) begin
          pend[s] = 1'b1;
          ids[s]  = ($urandom_range(0, 3) == 0) ? e_id_t'(0) : e_id_t'($urandom_range(1, 255));
        end
    for (int s = 0; s < NS; s++) begin
      sif.src_valid[s] = pend[s];
      sif.src_eid[s]   = ids[s];
    end
    enable_i = en;
    flush_i  = fl;
    #1;
    hs = 1'b0;
    g  = 0;
    if (en && !fl && mq.size() < DEPTH)
      for (int i = 0; i < NS; i++) begin
        int s;
        s = (m_rr + i) % NS;
        if (!hs && pend[s]) begin
          hs = 1'b1;
          g  = s;
        end
      end
    exp_rdy = '0;
    if (hs) exp_rdy[g] = 1'b1;
    chk("ready", 32'(sif.src_ready), 32'(exp_rdy));
    @(posedge clk);
    gid = '0;
    if (hs) begin
      gid     = ids[g];
      pend[g] = 1'b0;
      m_rr    = (g + 1) % NS;
      if (gid == 0 && m_drop != '1) m_drop = m_drop + 1'b1;
    end
    if (fl) begin
      m_eid = '0;
      mq.delete();
    end else if (mq.size() > 0) begin
      m_eid = mq.pop_front();
      if (hs && gid != 0) mq.push_back(gid);
    end else begin
      m_eid = (hs && gid != 0) ? gid : e_id_t'(0);
    end
    if (m_eid != 0) m_sent = m_sent + 1'b1;
    #1;
    chk("e_id", 32'(e_id_o), 32'(m_eid));
    chk("sent_cnt", 32'(sent_cnt_o), 32'(m_sent));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
  endtask

  initial begin
    sif.src_valid = '0;
    sif.src_eid   = '0;
    for (int s = 0; s < NS; s++) ids[s] = '0;
    en = 1'b1; fl = 1'b0; rand_src = 1'b0;
    model_reset();

    // reset state, with a request present and enable high
    enable_i = 1'b1;
    sif.src_valid = 4'b0001;
    sif.src_eid[0] = 8'h7a;
    #12;
    chk("rst_ready", 32'(sif.src_ready), 32'h0);
    chk("rst_eid", 32'(e_id_o), 32'h0);
    chk("rst_sent", 32'(sent_cnt_o), 32'h0);
    chk("rst_drop", 32'(drop_cnt_o), 32'h0);
    @(negedge clk);
    sif.src_valid = '0;
    rst = 1'b0;

    // three sources at once from rr_ptr 0: grants 0,2,3
    pend = 4'b1101;
    ids[0] = 8'h11; ids[2] = 8'h22; ids[3] = 8'h33;
    step(); chk("rr_e0", 32'(e_id_o), 32'h11);
    step(); chk("rr_e1", 32'(e_id_o), 32'h22);
    step(); chk("rr_e2", 32'(e_id_o), 32'h33);
    step(); chk("rr_idle", 32'(e_id_o), 32'h0);

    // single request on src1: one-cycle latency, single cycle on output
    pend[1] = 1'b1; ids[1] = 8'h05;
    step(); chk("single_eid", 32'(e_id_o), 32'h05);
    chk("single_sent", 32'(sent_cnt_o), 32'h4);
    step(); chk("single_after", 32'(e_id_o), 32'h0);

    // zero ID is consumed and counted, never forwarded
    pend[2] = 1'b1; ids[2] = 8'h00;
    step(); chk("zero_eid", 32'(e_id_o), 32'h0);
    chk("zero_drop", 32'(drop_cnt_o), 32'h1);

    // flush blocks grants; the held request bypasses afterwards
    fl = 1'b1; pend[0] = 1'b1; ids[0] = 8'h44;
    step(); chk("flush_eid", 32'(e_id_o), 32'h0);
    fl = 1'b0;
    step(); chk("post_flush_eid", 32'(e_id_o), 32'h44);

    // enable low holds ready low
    en = 1'b0; pend[3] = 1'b1; ids[3] = 8'h66;
    step(); step();
    chk("dis_eid", 32'(e_id_o), 32'h0);
    en = 1'b1;
    step(); chk("en_eid", 32'(e_id_o), 32'h66);

    // random traffic
    rand_src = 1'b1;
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 19) == 0);
      step();
    end
    en = 1'b1; fl = 1'b0;
    step(); step();

    // asynchronous reset mid-burst
    sif.src_valid = '1;
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(sif.src_ready), 32'h0);
    chk("arst_eid", 32'(e_id_o), 32'h0);
    chk("arst_sent", 32'(sent_cnt_o), 32'h0);
    chk("arst_drop", 32'(drop_cnt_o), 32'h0);
    model_reset();
    sif.src_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 100; c++) begin
      en = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
